time_keeper: RTL and testbench

- Datapath stage directly downstream of the stopwatch/timer mode FSM.
- Consumes `clear`, `enable`, `enable_increment` and `enable_decrement` from the FSM and keeps an MM:SS BCD time value.
- Counts up in stopwatch mode, is set by button steps in input mode, and counts down in timer mode.
- Returns `flag` to the FSM when the countdown reaches 00:00. `time_bcd` feeds the lap store and the display mux.

---
 rtl/time_pkg.sv | 19 +
 rtl/bcd_digit.sv | 36 +++
 rtl/time_keeper.sv | 145 ++++++++++++++
 tb/tb_time_keeper.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// Shared types and constants for the MM:SS BCD time value.
// Imported by the time keeper, the mode FSM and the lap store.
package time_pkg;

    typedef logic [3:0] digit_t;

    typedef struct packed {
        digit_t min_tens;
        digit_t min_ones;
        digit_t sec_tens;
        digit_t sec_ones;
    } time_t;

    localparam digit_t SEC_TENS_MAX     = 4'd5;
    localparam digit_t ONES_MAX         = 4'd9;
    localparam int     DEFAULT_TICK_DIV = 10_000_000;
    localparam time_t  TIME_ZERO        = '0;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit, counting 0..MAX with wrap, plus combinational carry/borrow
// so four instances can be chained into an MM:SS counter.
module bcd_digit
    import time_pkg::*;
#(
    parameter digit_t MAX = ONES_MAX
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   inc,
    input  logic   dec,
    input  logic   clr,
    input  logic   load,
    input  digit_t load_val,
    output digit_t val,
    output logic   carry,
    output logic   borrow
);

    // NOTE: reset sits inside the clocked block, so it only takes effect on a clock edge.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            val <= '0;
        end else if (load) begin
            val <= load_val;
        end else if (inc) begin
            val <= (val == MAX) ? '0 : val + 4'd1;
        end else if (dec) begin
            val <= (val == '0) ? MAX : val - 4'd1;
        end
    end

    assign carry  = inc && (val == MAX);
    assign borrow = dec && (val == '0);

endmodule

// File: rtl/time_keeper.sv
// MM:SS BCD time keeper: stopwatch up-count, step-set input mode and timer
// countdown with a sticky zero flag, driven by a one-second prescaler.
module time_keeper
    import time_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int STEP_SEC = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic        enable_increment,
    input  logic        enable_decrement,
    input  logic        step,
    output logic [15:0] time_bcd,
    output logic        tick,
    output logic        flag
);

    localparam int               CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam digit_t           STEP_TENS = digit_t'(STEP_SEC / 10);

    logic [CNT_W-1:0] count;
    time_t            cur;

    logic   run;
    logic   active;
    logic   is_zero;
    logic   is_one;
    logic   do_step;
    logic   dec_mode;
    logic   do_dec;
    logic   do_inc;
    logic   set_flag;
    digit_t st_sum;
    logic   step_carry;
    digit_t st_next;

    logic so_carry, so_borrow;
    logic st_carry, st_borrow;
    logic mo_carry, mo_borrow;
    logic mt_carry_unused, mt_borrow_unused;

    assign time_bcd = cur;
    assign is_zero  = (cur == TIME_ZERO);
    assign is_one   = (cur == time_t'(16'h0001));

    assign run    = (enable | enable_decrement) & ~flag & ~clear;
    assign active = ~clear & ~flag;

    // Update priority: step beats countdown beats up-count; clear overrides all.
    assign do_step  = active & enable_increment & step;
    assign dec_mode = active & ~do_step & enable_decrement;
    assign do_dec   = dec_mode & tick & ~is_zero;
    assign set_flag = dec_mode & (is_zero | (tick & is_one));
    assign do_inc   = active & ~do_step & ~(enable_decrement & tick) & enable & tick;

    // A step adds whole tens of seconds, so only sec_tens and the minutes move.
    assign st_sum     = cur.sec_tens + STEP_TENS;
    assign step_carry = (st_sum > SEC_TENS_MAX);
    assign st_next    = step_carry ? st_sum - 4'd6 : st_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
            flag  <= 1'b0;
        end else begin
            if (clear) begin
                flag <= 1'b0;
            end else if (set_flag) begin
                flag <= 1'b1;
            end

            if (run) begin
                if (count == CNT_LAST) begin
                    count <= '0;
                    tick  <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                    tick  <= 1'b0;
                end
            end else begin
                count <= '0;
                tick  <= 1'b0;
            end
        end
    end

    bcd_digit #(.MAX(ONES_MAX)) u_sec_ones (
        .clk      (clk),
        .rst      (rst),
        .inc      (do_inc),
        .dec      (do_dec),
        .clr      (clear),
        .load     (1'b0),
        .load_val (4'd0),
        .val      (cur.sec_ones),
        .carry    (so_carry),
        .borrow   (so_borrow)
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk      (clk),
        .rst      (rst),
        .inc      (so_carry),
        .dec      (so_borrow),
        .clr      (clear),
        .load     (do_step),
        .load_val (st_next),
        .val      (cur.sec_tens),
        .carry    (st_carry),
        .borrow   (st_borrow)
    );

    bcd_digit #(.MAX(ONES_MAX)) u_min_ones (
        .clk      (clk),
        .rst      (rst),
        .inc      (st_carry | (do_step & step_carry)),
        .dec      (st_borrow),
        .clr      (clear),
        .load     (1'b0),
        .load_val (4'd0),
        .val      (cur.min_ones),
        .carry    (mo_carry),
        .borrow   (mo_borrow)
    );

    // Wrapping past 59:59 is silent and a borrow below 00:00 cannot occur.
    bcd_digit #(.MAX(SEC_TENS_MAX)) u_min_tens (
        .clk      (clk),
        .rst      (rst),
        .inc      (mo_carry),
        .dec      (mo_borrow),
        .clr      (clear),
        .load     (1'b0),
        .load_val (4'd0),
        .val      (cur.min_tens),
        .carry    (mt_carry_unused),
        .borrow   (mt_borrow_unused)
    );

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: directed scenarios plus a randomized run,
// all compared against a seconds-based reference model.
module tb_time_keeper;

    localparam int TICK_DIV = 4;
    localparam int STEP_SEC = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic        enable_increment = 1'b0;
    logic        enable_decrement = 1'b0;
    logic        step = 1'b0;
    logic [15:0] time_bcd;
    logic        tick;
    logic        flag;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed value in whole seconds, running-cycle phase, tick and flag.
    int m_sec   = 0;
    int m_phase = 0;
    bit m_tick  = 1'b0;
    bit m_flag  = 1'b0;

    time_keeper #(
        .TICK_DIV (TICK_DIV),
        .STEP_SEC (STEP_SEC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .clear            (clear),
        .enable           (enable),
        .enable_increment (enable_increment),
        .enable_decrement (enable_decrement),
        .step             (step),
        .time_bcd         (time_bcd),
        .tick             (tick),
        .flag             (flag)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int s);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Advance one clock: model computes its next state from the current inputs,
    // then the DUT is sampled 1 ns after the rising edge.
    task automatic cycle();
        int nsec;
        int nphase;
        bit nflag;
        bit ntick;
        bit running;
        running = (enable || enable_decrement) && !m_flag && !clear;
        if (rst) begin
            nsec = 0; nphase = 0; nflag = 1'b0; ntick = 1'b0;
        end else begin
            nsec  = m_sec;
            nflag = m_flag;
            if (running) begin
                ntick  = (m_phase == TICK_DIV - 1);
                nphase = (m_phase + 1) % TICK_DIV;
            end else begin
                ntick  = 1'b0;
                nphase = 0;
            end
            if (clear) begin
                nsec  = 0;
                nflag = 1'b0;
            end else if (!m_flag) begin
                if (enable_increment && step) begin
                    nsec = (m_sec + STEP_SEC) % 3600;
                end else if (enable_decrement && m_tick && m_sec != 0) begin
                    nsec = m_sec - 1;
                    if (nsec == 0) nflag = 1'b1;
                end else if (enable_decrement && m_sec == 0) begin
                    nflag = 1'b1;
                end else if (enable && m_tick) begin
                    nsec = (m_sec + 1) % 3600;
                end
            end
        end
        @(posedge clk);
        #1;
        m_sec = nsec; m_phase = nphase; m_flag = nflag; m_tick = ntick;
    endtask

    task automatic do_clear();
        enable = 1'b0; enable_increment = 1'b0; enable_decrement = 1'b0; step = 1'b0;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic pulse_steps(input int n);
        for (int k = 0; k < n; k++) begin
            step = 1'b1;
            cycle();
            step = 1'b0;
            cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        checks++;
        if ({time_bcd, tick, flag} !== {16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got time=%h tick=%b flag=%b, expected 0000/0/0", time_bcd, tick, flag);
        end
    endtask

    task automatic test_stopwatch();
        enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            cycle();
            checks++;
            if ({time_bcd, tick, flag} !== {to_bcd(m_sec), m_tick, m_flag}) begin
                errors++;
                $display("FAIL stopwatch_model cyc %0d: got %h/%b/%b, expected %h/%b/%b",
                         i, time_bcd, tick, flag, to_bcd(m_sec), m_tick, m_flag);
            end
            if (i <= 8) begin
                checks++;
                if (tick !== (i == 4 || i == 8)) begin
                    errors++;
                    $display("FAIL stopwatch_tick cyc %0d: got %b, expected %b", i, tick, (i == 4 || i == 8));
                end
            end
        end
        checks++;
        if (time_bcd !== 16'h0002) begin
            errors++;
            $display("FAIL stopwatch_value: got %h, expected 0002", time_bcd);
        end
    endtask

    task automatic test_step();
        do_clear();
        enable_increment = 1'b1;
        pulse_steps(7);
        checks++;
        if (time_bcd !== 16'h0110) begin
            errors++;
            $display("FAIL step_set: got %h, expected 0110", time_bcd);
        end
        enable_increment = 1'b0;
        pulse_steps(3);
        checks++;
        if (time_bcd !== 16'h0110 || time_bcd !== to_bcd(m_sec)) begin
            errors++;
            $display("FAIL step_ignored: got %h, expected 0110", time_bcd);
        end
    endtask

    task automatic test_wrap();
        do_clear();
        enable_increment = 1'b1;
        pulse_steps(359);
        enable_increment = 1'b0;
        checks++;
        if (time_bcd !== 16'h5950) begin
            errors++;
            $display("FAIL wrap_preload: got %h, expected 5950", time_bcd);
        end
        enable = 1'b1;
        for (int i = 1; i <= 41; i++) begin
            cycle();
            checks++;
            if ({time_bcd, tick, flag} !== {to_bcd(m_sec), m_tick, m_flag}) begin
                errors++;
                $display("FAIL wrap_model cyc %0d: got %h/%b/%b, expected %h/%b/%b",
                         i, time_bcd, tick, flag, to_bcd(m_sec), m_tick, m_flag);
            end
            if (i == 37) begin
                checks++;
                if (time_bcd !== 16'h5959) begin
                    errors++;
                    $display("FAIL wrap_5959: got %h, expected 5959", time_bcd);
                end
            end
        end
        checks++;
        if ({time_bcd, flag} !== {16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL wrap_zero: got time=%h flag=%b, expected 0000/0", time_bcd, flag);
        end
        enable = 1'b0;
    endtask

    task automatic test_countdown();
        do_clear();
        enable_increment = 1'b1;
        pulse_steps(2);
        enable_increment = 1'b0;
        enable_decrement = 1'b1;
        for (int i = 1; i <= 101; i++) begin
            cycle();
            checks++;
            if ({time_bcd, tick, flag} !== {to_bcd(m_sec), m_tick, m_flag}) begin
                errors++;
                $display("FAIL countdown_model cyc %0d: got %h/%b/%b, expected %h/%b/%b",
                         i, time_bcd, tick, flag, to_bcd(m_sec), m_tick, m_flag);
            end
            if (i == 5) begin
                checks++;
                if (time_bcd !== 16'h0019) begin
                    errors++;
                    $display("FAIL countdown_first: got %h, expected 0019", time_bcd);
                end
            end
            if (i == 80 || i >= 81) begin
                checks++;
                if (flag !== (i >= 81) || (i >= 81 && (time_bcd !== 16'h0000 || (i > 81 && tick !== 1'b0)))) begin
                    errors++;
                    $display("FAIL countdown_end cyc %0d: got time=%h tick=%b flag=%b, expected flag=%b time=0000",
                             i, time_bcd, tick, flag, (i >= 81));
                end
            end
        end
        enable_decrement = 1'b0;
    endtask

    task automatic test_zero_start();
        do_clear();
        enable_decrement = 1'b1;
        cycle();
        checks++;
        if ({time_bcd, flag} !== {16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL zero_start: got time=%h flag=%b, expected 0000/1", time_bcd, flag);
        end
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        checks++;
        if ({time_bcd, flag} !== {16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL zero_clear: got time=%h flag=%b, expected 0000/0", time_bcd, flag);
        end
        enable_decrement = 1'b0;
        cycle();
    endtask

    task automatic test_borrow();
        logic [15:0] presets [2]  = '{16'h0100, 16'h1000};
        logic [15:0] results [2]  = '{16'h0059, 16'h0959};
        int          nsteps  [2]  = '{6, 60};
        for (int t = 0; t < 2; t++) begin
            do_clear();
            enable_increment = 1'b1;
            pulse_steps(nsteps[t]);
            enable_increment = 1'b0;
            checks++;
            if (time_bcd !== presets[t]) begin
                errors++;
                $display("FAIL borrow_preload %0d: got %h, expected %h", t, time_bcd, presets[t]);
            end
            enable_decrement = 1'b1;
            repeat (TICK_DIV + 1) cycle();
            enable_decrement = 1'b0;
            checks++;
            if ({time_bcd, flag} !== {results[t], 1'b0} || time_bcd !== to_bcd(m_sec)) begin
                errors++;
                $display("FAIL borrow %0d: got time=%h flag=%b, expected %h/0", t, time_bcd, flag, results[t]);
            end
        end
    endtask

    task automatic test_reset_priority();
        do_clear();
        enable_increment = 1'b1;
        pulse_steps(4);
        enable_increment = 1'b0;
        enable_decrement = 1'b1;
        repeat (3 * TICK_DIV + 1) cycle();
        checks++;
        if (time_bcd !== 16'h0037) begin
            errors++;
            $display("FAIL rst_preload: got %h, expected 0037", time_bcd);
        end
        repeat (2) cycle();
        rst = 1'b1; step = 1'b1; enable = 1'b1;
        cycle();
        checks++;
        if ({time_bcd, tick, flag} !== {16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_priority: got time=%h tick=%b flag=%b, expected 0000/0/0", time_bcd, tick, flag);
        end
        rst = 1'b0; step = 1'b0; enable_decrement = 1'b0;
        for (int i = 1; i <= TICK_DIV; i++) begin
            cycle();
            checks++;
            if ({time_bcd, tick, flag} !== {16'h0000, (i == TICK_DIV), 1'b0}) begin
                errors++;
                $display("FAIL rst_restart cyc %0d: got time=%h tick=%b flag=%b, expected 0000/%b/0",
                         i, time_bcd, tick, flag, (i == TICK_DIV));
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_random();
        int mode = 8;
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) mode = $urandom_range(0, 9);
            enable           = (mode <= 2) || (mode == 9 && $urandom_range(0, 1) == 1);
            enable_decrement = (mode >= 3 && mode <= 5) || (mode == 9 && $urandom_range(0, 1) == 1);
            enable_increment = (mode >= 6 && mode <= 7) || (mode == 9 && $urandom_range(0, 1) == 1);
            step             = ($urandom_range(0, 3) == 0);
            clear            = ($urandom_range(0, 199) == 0);
            rst              = ($urandom_range(0, 499) == 0);
            cycle();
            checks++;
            if ({time_bcd, tick, flag} !== {to_bcd(m_sec), m_tick, m_flag}) begin
                errors++;
                $display("FAIL random cyc %0d: got %h/%b/%b, expected %h/%b/%b",
                         i, time_bcd, tick, flag, to_bcd(m_sec), m_tick, m_flag);
            end
        end
        rst = 1'b0; clear = 1'b0; step = 1'b0;
        enable = 1'b0; enable_increment = 1'b0; enable_decrement = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stopwatch();
        test_step();
        test_wrap();
        test_countdown();
        test_zero_start();
        test_borrow();
        test_reset_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
